// File: rtl/relu_maxpool.sv
// relu_maxpool: optional ReLU followed by 2x2 stride-2 max pooling, per channel.
//
// Sits behind the convolution block and consumes its per-channel pixel stream.
// Each channel keeps one half-width line buffer that holds the horizontal maxima
// of the even row. The odd row combines those maxima with its own horizontal
// maxima to form the pooled result.
//
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   clk_en   - global clock enable; every register holds while it is low
//   i_data   - signed input pixel, one per channel
//   i_valid  - input pixel valid
//   i_sop    - first pixel of a frame (qualified by i_valid)
//   i_eop    - last pixel of a frame (qualified by i_valid)
//   o_data   - pooled pixel, one per channel (holds its value while o_valid is low)
//   o_valid  - pooled pixel valid, high for one enabled cycle per result
//   o_sop    - first pooled pixel of a frame
//   o_eop    - last pooled pixel of a frame
module relu_maxpool #(
  parameter int PIX_WIDTH  = 8,
  parameter int CHANNELS   = 4,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26,
  parameter int RELU       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_en,
  input  logic [CHANNELS-1:0][PIX_WIDTH-1:0]   i_data,
  input  logic                                 i_valid,
  input  logic                                 i_sop,
  input  logic                                 i_eop,
  output logic [CHANNELS-1:0][PIX_WIDTH-1:0]   o_data,
  output logic                                 o_valid,
  output logic                                 o_sop,
  output logic                                 o_eop
);

  localparam int HALF_W   = IMG_WIDTH / 2;
  localparam int HALF_H   = IMG_HEIGHT / 2;
  // The pooled region excludes a trailing odd column/row.
  localparam int POOL_W   = 2 * HALF_W;
  localparam int POOL_H   = 2 * HALF_H;
  localparam int CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW       = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int LB_DEPTH = (HALF_W > 0) ? HALF_W : 1;

  typedef logic signed [PIX_WIDTH-1:0] pix_t;

  // Signed maximum of two pixels; the result is always one of the operands.
  function automatic pix_t smax(input pix_t a, input pix_t b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Clamps negative pixels to zero when ReLU is enabled.
  function automatic pix_t relu_f(input pix_t p);
    if ((RELU != 0) && p[PIX_WIDTH-1]) begin
      return {PIX_WIDTH{1'b0}};
    end else begin
      return p;
    end
  endfunction

  logic [CW-1:0] col_r, col_s, col_nxt_s;
  logic [RW-1:0] row_r, row_s, row_nxt_s;
  logic          accept_s;
  logic          in_pool_s;
  logic          col_odd_s;
  logic          row_odd_s;
  logic          emit_s;
  logic          sop_hit_s;
  logic          eop_hit_s;
  logic [AW-1:0] lb_idx_s;

  pix_t px_s      [CHANNELS];
  pix_t h_s       [CHANNELS];
  pix_t res_s     [CHANNELS];
  pix_t hmax_r    [CHANNELS];
  pix_t linebuf_r [CHANNELS][LB_DEPTH];

  // Effective pixel position (i_sop forces a restart at 0,0) and next counter values.
  always_comb begin
    accept_s  = clk_en & i_valid;
    col_s     = col_r;
    row_s     = row_r;
    col_nxt_s = {CW{1'b0}};
    row_nxt_s = {RW{1'b0}};
    if (i_sop) begin
      col_s = {CW{1'b0}};
      row_s = {RW{1'b0}};
    end else begin
      col_s = col_r;
      row_s = row_r;
    end
    col_odd_s = col_s[0];
    row_odd_s = row_s[0];
    in_pool_s = (int'(col_s) < POOL_W) && (int'(row_s) < POOL_H);
    lb_idx_s  = AW'(col_s >> 1);
    if (i_eop) begin
      col_nxt_s = {CW{1'b0}};
      row_nxt_s = {RW{1'b0}};
    end else if (col_s == CW'(IMG_WIDTH - 1)) begin
      col_nxt_s = {CW{1'b0}};
      if (row_s == RW'(IMG_HEIGHT - 1)) begin
        row_nxt_s = {RW{1'b0}};
      end else begin
        row_nxt_s = row_s + RW'(1);
      end
    end else begin
      col_nxt_s = col_s + CW'(1);
      row_nxt_s = row_s;
    end
    emit_s    = accept_s & in_pool_s & col_odd_s & row_odd_s;
    sop_hit_s = (row_s == RW'(1)) && (col_s == CW'(1));
    eop_hit_s = (row_s == RW'(POOL_H - 1)) && (col_s == CW'(POOL_W - 1));
  end

  // Per-channel ReLU, horizontal max and final vertical max.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      px_s[ch]  = relu_f(pix_t'(i_data[ch]));
      h_s[ch]   = smax(hmax_r[ch], px_s[ch]);
      res_s[ch] = smax(linebuf_r[ch][lb_idx_s], h_s[ch]);
    end
  end

  // Position counters and the even-column horizontal max registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
      for (int ch = 0; ch < CHANNELS; ch++) begin
        hmax_r[ch] <= {PIX_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
      if (in_pool_s && !col_odd_s) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          hmax_r[ch] <= px_s[ch];
        end
      end
    end
  end

  // Line buffer: even-row horizontal maxima, read back on the odd row. Not reset,
  // since every entry is rewritten on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (accept_s && in_pool_s && col_odd_s && !row_odd_s) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        linebuf_r[ch][lb_idx_s] <= h_s[ch];
      end
    end
  end

  // Registered output stage; flags only pulse together with a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_data  <= {(CHANNELS * PIX_WIDTH){1'b0}};
    end else if (clk_en) begin
      o_valid <= emit_s;
      o_sop   <= emit_s & sop_hit_s;
      o_eop   <= emit_s & eop_hit_s;
      if (emit_s) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          o_data[ch] <= res_s[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool. Two 4x4 instances (RELU=1 and RELU=0) share
// the square-frame stimulus; a 5x5 RELU=0 instance checks odd-dimension handling.
// Channel 0 carries the directed value, channel 1 carries its negation.
module tb_relu_maxpool;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sop;
    logic       eop;
    int         due;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            clk_en;
  logic [1:0][7:0] din;
  logic            v_sq;
  logic            v_odd;
  logic            sop;
  logic            eop;

  logic [1:0][7:0] d_r1, d_r0, d_odd;
  logic            ov_r1, ov_r0, ov_odd;
  logic            os_r1, os_r0, os_odd;
  logic            oe_r1, oe_r0, oe_odd;

  exp_t q_r1[$];
  exp_t q_r0[$];
  exp_t q_odd[$];

  int   total  = 0;
  int   passed = 0;
  int   en_cnt = 0;
  logic en_edge = 1'b0;

  relu_maxpool #(.PIX_WIDTH(8), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(din), .i_valid(v_sq),
    .i_sop(sop), .i_eop(eop), .o_data(d_r1), .o_valid(ov_r1), .o_sop(os_r1), .o_eop(oe_r1)
  );

  relu_maxpool #(.PIX_WIDTH(8), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4), .RELU(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(din), .i_valid(v_sq),
    .i_sop(sop), .i_eop(eop), .o_data(d_r0), .o_valid(ov_r0), .o_sop(os_r0), .o_eop(oe_r0)
  );

  relu_maxpool #(.PIX_WIDTH(8), .CHANNELS(2), .IMG_WIDTH(5), .IMG_HEIGHT(5), .RELU(0)) u_odd (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(din), .i_valid(v_odd),
    .i_sop(sop), .i_eop(eop), .o_data(d_odd), .o_valid(ov_odd), .o_sop(os_odd), .o_eop(oe_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count enabled edges so each expected result carries the edge it is due on.
  always @(posedge clk) begin
    en_edge <= clk_en;
    if (clk_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic push(input int which, input int v0, input int v1, input logic s, input logic e);
    exp_t x;
    x.d0  = 8'(v0);
    x.d1  = 8'(v1);
    x.sop = s;
    x.eop = e;
    x.due = en_cnt + 1;
    case (which)
      0: q_r0.push_back(x);
      1: q_r1.push_back(x);
      default: q_odd.push_back(x);
    endcase
  endtask

  task automatic mon(input int which, input logic [15:0] d, input logic s, input logic e);
    exp_t  x;
    string nm;
    int    sz;
    nm = (which == 0) ? "out_r0" : (which == 1) ? "out_r1" : "out_odd";
    case (which)
      0: sz = q_r0.size();
      1: sz = q_r1.size();
      default: sz = q_odd.size();
    endcase
    total++;
    if (sz == 0) begin
      $display("FAIL %s: unexpected o_valid data=%h sop=%b eop=%b at edge %0d", nm, d, s, e, en_cnt);
    end else begin
      case (which)
        0: x = q_r0.pop_front();
        1: x = q_r1.pop_front();
        default: x = q_odd.pop_front();
      endcase
      if ({d, s, e} === {x.d1, x.d0, x.sop, x.eop} && en_cnt == x.due) passed++;
      else $display("FAIL %s: got data=%h sop=%b eop=%b edge=%0d, expected data=%h sop=%b eop=%b edge=%0d",
                    nm, d, s, e, en_cnt, {x.d1, x.d0}, x.sop, x.eop, x.due);
    end
  endtask

  // Monitor: one result per o_valid seen after an enabled edge.
  always @(negedge clk) begin
    if (rst_n && en_edge) begin
      if (ov_r0)  mon(0, d_r0, os_r0, oe_r0);
      if (ov_r1)  mon(1, d_r1, os_r1, oe_r1);
      if (ov_odd) mon(2, d_odd, os_odd, oe_odd);
    end
  end

  task automatic drive(input int v0, input int v1, input logic s, input logic e,
                       input logic en, input logic vs, input logic vo);
    @(posedge clk);
    #1;
    din    = {8'(v1), 8'(v0)};
    sop    = s;
    eop    = e;
    clk_en = en;
    v_sq   = vs;
    v_odd  = vo;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // 4x4 ramp base..base+n-1; windows complete at indices 5,7,13,15 and the
  // window's top-left pixel is index-5, which is the channel-1 maximum.
  task automatic frame4(input int base, input int n, input logic use_sop,
                        input int eop_idx, input logic gated);
    for (int idx = 0; idx < n; idx++) begin
      if (gated) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          logic r;
          r = 1'($urandom_range(0, 1));
          drive(99, 99, 1'b1, 1'b1, r, ~r, 1'b0);
        end
      end
      drive(base + idx, -(base + idx), use_sop && idx == 0, idx == eop_idx, 1'b1, 1'b1, 1'b0);
      if (idx == 5 || idx == 7 || idx == 13 || idx == 15) begin
        push(0, base + idx, -(base + idx - 5), idx == 5, idx == 15);
        push(1, base + idx, 0, idx == 5, idx == 15);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_r0"}, {13'd0, ov_r0, os_r0, oe_r0, d_r0}, 32'd0);
    chk({tag, "_r1"}, {13'd0, ov_r1, os_r1, oe_r1, d_r1}, 32'd0);
    chk({tag, "_odd"}, {13'd0, ov_odd, os_odd, oe_odd, d_odd}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b0;
    din    = 16'd0;
    v_sq   = 1'b0;
    v_odd  = 1'b0;
    sop    = 1'b0;
    eop    = 1'b0;
    @(negedge clk);
    chk_reset("reset_init");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Plain ramp, then a frame started only by counter wrap.
    frame4(0, 16, 1'b1, 15, 1'b0);
    frame4(0, 16, 1'b0, -1, 1'b0);
    idle(2);

    // Constant -3 / +2 frame: ReLU clamps channel 0 only in u_r1.
    for (int idx = 0; idx < 16; idx++) begin
      drive(-3, 2, idx == 0, idx == 15, 1'b1, 1'b1, 1'b0);
      if (idx == 5 || idx == 7 || idx == 13 || idx == 15) begin
        push(0, -3, 2, idx == 5, idx == 15);
        push(1, 0, 2, idx == 5, idx == 15);
      end
    end
    idle(2);

    // Ramp with clk_en / i_valid gaps carrying junk sop/eop/data.
    frame4(0, 16, 1'b1, 15, 1'b1);
    idle(2);

    // 5x5 frame: row 4 and column 4 are dropped.
    for (int idx = 0; idx < 25; idx++) begin
      drive(idx, -idx, idx == 0, idx == 24, 1'b1, 1'b0, 1'b1);
      if (idx == 6 || idx == 8 || idx == 16 || idx == 18)
        push(2, idx, -(idx - 6), idx == 6, idx == 18);
    end
    idle(2);

    // Mid-frame restart after pixel 6, then a full 100..115 frame.
    frame4(0, 7, 1'b1, -1, 1'b0);
    frame4(100, 16, 1'b1, 15, 1'b0);
    idle(2);

    // Early eop truncation, a one-pixel sop+eop frame, then a frame from counter zero.
    frame4(0, 10, 1'b1, 9, 1'b0);
    drive(50, -50, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    frame4(0, 16, 1'b0, 15, 1'b0);
    idle(2);

    // Reset after pixel 9, then a clean ramp.
    frame4(0, 10, 1'b1, -1, 1'b0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("reset_mid_a");
    @(negedge clk);
    chk_reset("reset_mid_b");
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame4(0, 16, 1'b1, 15, 1'b0);
    idle(4);

    chk("drain_r0", q_r0.size(), 32'd0);
    chk("drain_r1", q_r1.size(), 32'd0);
    chk("drain_odd", q_odd.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
